// File: rtl/rf_multiport_if.sv
// rtl/rf_multiport_if.sv - read/write/reserve bus of the multi-port register file
interface rf_multiport_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [ADDR_W:0]          pend_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, pend_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, pend_cnt
  );
endinterface

// File: rtl/rf_multiport.sv
// rtl/rf_multiport.sv - multi-read-port register file with pending-write scoreboard (optional RF_BYPASS_EN write-through)
module rf_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  rf_multiport_if.slave rf_if
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   pend_cnt_q, pend_cnt_d;

  logic wr_eff;
  logic rsv_eff;
  logic cnt_inc;
  logic cnt_dec;

  logic [NUM_RD*DATA_W-1:0] rd_data_w;
  logic [NUM_RD-1:0]        rd_busy_w;

  // Qualify write/reserve strobes: the hard-wired zero register swallows both
  always_comb begin
    wr_eff  = rf_if.wr_en;
    rsv_eff = rf_if.rsv_en;
    if ((ZERO_REG != 0) && (rf_if.wr_addr == '0)) wr_eff = 1'b0;
    if ((ZERO_REG != 0) && (rf_if.rsv_addr == '0)) rsv_eff = 1'b0;
  end

  // Busy-bit and pending-count next state; a reservation overrides a same-address clear
  always_comb begin
    busy_d  = busy_q;
    cnt_inc = 1'b0;
    cnt_dec = 1'b0;
    if (wr_eff) begin
      busy_d[rf_if.wr_addr] = 1'b0;
      cnt_dec = busy_q[rf_if.wr_addr] &&
                !(rsv_eff && (rf_if.rsv_addr == rf_if.wr_addr));
    end
    if (rsv_eff) begin
      busy_d[rf_if.rsv_addr] = 1'b1;
      cnt_inc = !busy_q[rf_if.rsv_addr];
    end
    pend_cnt_d = pend_cnt_q + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
  end

  // Scoreboard state: busy bits and their population count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  // Register storage: cleared on reset, one write per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_eff) begin
      mem_q[rf_if.wr_addr] <= rf_if.wr_data;
    end
  end

  // Combinational read ports, each independent; forwarding is held off during reset
  always_comb begin
    rd_data_w = '0;
    rd_busy_w = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [ADDR_W-1:0] a;
      a = rf_if.rd_addr[p*ADDR_W +: ADDR_W];
      rd_data_w[p*DATA_W +: DATA_W] = mem_q[a];
      rd_busy_w[p]                  = busy_q[a];
`ifdef RF_BYPASS_EN
      if (rst_n && wr_eff && (a == rf_if.wr_addr)) begin
        rd_data_w[p*DATA_W +: DATA_W] = rf_if.wr_data;
        rd_busy_w[p]                  = rsv_eff && (rf_if.rsv_addr == a);
      end
`endif
      if ((ZERO_REG != 0) && (a == '0)) begin
        rd_data_w[p*DATA_W +: DATA_W] = '0;
        rd_busy_w[p]                  = 1'b0;
      end
    end
  end

  assign rf_if.rd_data  = rd_data_w;
  assign rf_if.rd_busy  = rd_busy_w;
  assign rf_if.pend_cnt = pend_cnt_q;
endmodule

// File: tb/tb_rf_multiport.sv
// tb/tb_rf_multiport.sv - self-checking bench for rf_multiport (default and 4-port/8-entry builds)
module tb_rf_multiport;
  logic clk;
  logic rst_n;

  rf_multiport_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus0 ();
  rf_multiport_if #(.DATA_W(32), .ADDR_W(3), .NUM_RD(4)) bus1 ();

  rf_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .rf_if(bus0.slave));
  rf_multiport #(.DATA_W(32), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .rf_if(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic [1:0]  ebusy;
    logic [5:0]  ecnt;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic [1:0]  ebusy;
    logic [5:0]  ecnt;
  } exp_t;

  vec_t vecs[12];
  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic apply_vec(input int idx);
    exp_t e;
    @(negedge clk);
    bus0.wr_en    = vecs[idx].wr_en;
    bus0.wr_addr  = vecs[idx].wr_addr;
    bus0.wr_data  = vecs[idx].wr_data;
    bus0.rsv_en   = vecs[idx].rsv_en;
    bus0.rsv_addr = vecs[idx].rsv_addr;
    e.name  = $sformatf("vec%0d", idx);
    e.ed0   = vecs[idx].ed0;
    e.ed1   = vecs[idx].ed1;
    e.ebusy = vecs[idx].ebusy;
    e.ecnt  = vecs[idx].ecnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus0.wr_en   = 1'b0;
    bus0.rsv_en  = 1'b0;
    bus0.rd_addr = {vecs[idx].ra1, vecs[idx].ra0};
    #1;
    e = sb_q.pop_front();
    chk({e.name, "_rd0"},  bus0.rd_data[31:0],  e.ed0);
    chk({e.name, "_rd1"},  bus0.rd_data[63:32], e.ed1);
    chk({e.name, "_busy"}, {30'd0, bus0.rd_busy}, {30'd0, e.ebusy});
    chk({e.name, "_cnt"},  {26'd0, bus0.pend_cnt}, {26'd0, e.ecnt});
  endtask

  task automatic write0(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus0.wr_en = 1'b1; bus0.wr_addr = a; bus0.wr_data = d;
    @(posedge clk);
    #1;
    bus0.wr_en = 1'b0;
  endtask

  initial begin
    //            wr  waddr  wdata          rsv raddr  ra0    ra1    ed0            ed1            busy   cnt
    vecs[0]  = '{1'b1, 5'd9,  32'hDEADBEEF, 1'b0, 5'd0,  5'd9,  5'd9,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 6'd0};
    vecs[1]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  5'd0,  5'd9,  32'h0,        32'hDEADBEEF, 2'b00, 6'd0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 5'd10, 5'd9,  32'h0,        32'hDEADBEEF, 2'b01, 6'd1};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 5'd10, 5'd11, 32'h0,        32'h0,        2'b11, 6'd2};
    vecs[4]  = '{1'b1, 5'd10, 32'h7,        1'b0, 5'd0,  5'd10, 5'd11, 32'h7,        32'h0,        2'b10, 6'd1};
    vecs[5]  = '{1'b1, 5'd12, 32'h6,        1'b1, 5'd12, 5'd12, 5'd11, 32'h6,        32'h0,        2'b11, 6'd2};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 5'd11, 5'd12, 32'h0,        32'h6,        2'b11, 6'd2};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 6'd2};
    vecs[8]  = '{1'b1, 5'd11, 32'h5,        1'b1, 5'd13, 5'd11, 5'd13, 32'h5,        32'h0,        2'b10, 6'd2};
    vecs[9]  = '{1'b1, 5'd12, 32'h9,        1'b0, 5'd0,  5'd12, 5'd13, 32'h9,        32'h0,        2'b10, 6'd1};
    vecs[10] = '{1'b1, 5'd13, 32'h3,        1'b0, 5'd0,  5'd13, 5'd12, 32'h3,        32'h9,        2'b00, 6'd0};
    vecs[11] = '{1'b0, 5'd9,  32'hFFFFFFFF, 1'b0, 5'd0,  5'd9,  5'd9,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 6'd0};

    rst_n = 1'b0;
    bus0.wr_en = 1'b0; bus0.wr_addr = '0; bus0.wr_data = '0;
    bus0.rsv_en = 1'b0; bus0.rsv_addr = '0; bus0.rd_addr = {5'd9, 5'd1};
    bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0;
    bus1.rsv_en = 1'b0; bus1.rsv_addr = '0; bus1.rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd",   bus0.rd_data[31:0], 32'h0);
    chk("reset_busy", {30'd0, bus0.rd_busy}, 32'h0);
    chk("reset_cnt",  {26'd0, bus0.pend_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) apply_vec(i);

    // Write-through vs. next-cycle visibility
    write0(5'd9, 32'h6);
    @(negedge clk);
    bus0.wr_en = 1'b1; bus0.wr_addr = 5'd9; bus0.wr_data = 32'h8; bus0.rd_addr = {5'd9, 5'd9};
    #1;
`ifdef RF_BYPASS_EN
    chk("byp_same_cycle", bus0.rd_data[31:0], 32'h8);
`else
    chk("byp_same_cycle", bus0.rd_data[31:0], 32'h6);
`endif
    chk("byp_same_busy", {31'd0, bus0.rd_busy[0]}, 32'h0);
    @(posedge clk);
    #1;
    bus0.wr_en = 1'b0;
    #1;
    chk("byp_next_cycle", bus0.rd_data[31:0], 32'h8);

    // Write plus reservation to the same register seen through the read port
    @(negedge clk);
    bus0.wr_en = 1'b1; bus0.wr_addr = 5'd14; bus0.wr_data = 32'h1;
    bus0.rsv_en = 1'b1; bus0.rsv_addr = 5'd14; bus0.rd_addr = {5'd14, 5'd14};
    #1;
`ifdef RF_BYPASS_EN
    chk("byp_rsv_data", bus0.rd_data[31:0], 32'h1);
    chk("byp_rsv_busy", {31'd0, bus0.rd_busy[0]}, 32'h1);
`else
    chk("byp_rsv_data", bus0.rd_data[31:0], 32'h0);
    chk("byp_rsv_busy", {31'd0, bus0.rd_busy[0]}, 32'h0);
`endif
    @(posedge clk);
    #1;
    bus0.wr_en = 1'b0; bus0.rsv_en = 1'b0;
    #1;
    chk("wr_rsv_data", bus0.rd_data[31:0], 32'h1);
    chk("wr_rsv_busy", {31'd0, bus0.rd_busy[0]}, 32'h1);
    chk("wr_rsv_cnt",  {26'd0, bus0.pend_cnt}, 32'h1);

    // Asynchronous reset mid-cycle with a write and reservation pending
    @(negedge clk);
    bus0.wr_en = 1'b1; bus0.wr_addr = 5'd9; bus0.wr_data = 32'h77;
    bus0.rsv_en = 1'b1; bus0.rsv_addr = 5'd15; bus0.rd_addr = {5'd14, 5'd9};
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rd0",  bus0.rd_data[31:0],  32'h0);
    chk("arst_rd1",  bus0.rd_data[63:32], 32'h0);
    chk("arst_busy", {30'd0, bus0.rd_busy}, 32'h0);
    chk("arst_cnt",  {26'd0, bus0.pend_cnt}, 32'h0);
    @(posedge clk);
    #1;
    chk("arst_hold_rd0", bus0.rd_data[31:0], 32'h0);
    chk("arst_hold_cnt", {26'd0, bus0.pend_cnt}, 32'h0);
    @(negedge clk);
    bus0.wr_en = 1'b0; bus0.rsv_en = 1'b0; rst_n = 1'b1;
    bus0.rd_addr = {5'd15, 5'd9};
    #1;
    chk("arst_discard_wr",  bus0.rd_data[31:0], 32'h0);
    chk("arst_discard_rsv", {31'd0, bus0.rd_busy[1]}, 32'h0);

    // 4-port, 8-entry build without a zero register: fill and drain the scoreboard
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      bus1.rsv_en = 1'b1; bus1.rsv_addr = 3'(r);
      @(posedge clk);
      #1;
      bus1.rsv_en = 1'b0;
      chk($sformatf("fill_cnt%0d", r), {28'd0, bus1.pend_cnt}, 32'(r + 1));
    end
    @(negedge clk);
    bus1.rsv_en = 1'b1; bus1.rsv_addr = 3'd3;
    @(posedge clk);
    #1;
    bus1.rsv_en = 1'b0;
    bus1.rd_addr = {3'd7, 3'd5, 3'd3, 3'd0};
    #1;
    chk("full_cnt_nowrap", {28'd0, bus1.pend_cnt}, 32'd8);
    chk("full_busy", {28'd0, bus1.rd_busy}, 32'hF);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      bus1.wr_en = 1'b1; bus1.wr_addr = 3'(r); bus1.wr_data = 32'h100 + 32'(r) * 32'h11;
      @(posedge clk);
      #1;
      bus1.wr_en = 1'b0;
      chk($sformatf("drain_cnt%0d", r), {28'd0, bus1.pend_cnt}, 32'(7 - r));
    end
    bus1.rd_addr = {3'd7, 3'd6, 3'd1, 3'd0};
    #1;
    chk("p4_rd0", bus1.rd_data[31:0],   32'h100);
    chk("p4_rd1", bus1.rd_data[63:32],  32'h111);
    chk("p4_rd2", bus1.rd_data[95:64],  32'h166);
    chk("p4_rd3", bus1.rd_data[127:96], 32'h177);
    chk("p4_busy", {28'd0, bus1.rd_busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
